// File: rtl/huff_encode.sv
// Canonical Huffman encoder: length table load, canonical code build,
// then serialises one symbol's code MSB-first per handshake.
module huff_encode #(
    parameter int NSYM   = 16,
    parameter int MAXLEN = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       len_we,
    input  logic [3:0] len_addr,
    input  logic [3:0] len_data,
    input  logic       build,
    output logic       build_done,
    input  logic       sym_valid,
    input  logic [3:0] sym,
    output logic       sym_ready,
    output logic       bit_valid,
    output logic       bit_out,
    output logic       bit_last,
    input  logic       bit_ready,
    output logic       busy,
    output logic       err
);
    localparam int CW = 16;                 // code / next_code arithmetic width
    localparam int BW = $clog2(NSYM + 1);   // bl_count must hold NSYM

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_COUNT  = 3'd1;
    localparam logic [2:0] S_NEXTC  = 3'd2;
    localparam logic [2:0] S_ASSIGN = 3'd3;
    localparam logic [2:0] S_READY  = 3'd4;
    localparam logic [2:0] S_SHIFT  = 3'd5;

    logic [2:0]                  state;
    logic [3:0]                  cnt;
    logic [NSYM-1:0][3:0]        len_tab;
    logic [NSYM-1:0][CW-1:0]     code_tab;
    logic [MAXLEN:0][BW-1:0]     bl_count;
    logic [MAXLEN:0][CW-1:0]     next_code;
    logic [CW-1:0]               code_acc;
    logic [CW-1:0]               shreg;
    logic [3:0]                  rem;

    logic [3:0]    cur_len;
    logic [CW-1:0] nc_sel;
    logic [CW-1:0] acc_nxt;
    logic          oversub;

    // Per-step helpers for the build walk; cnt indexes symbol or bit length.
    always_comb begin
        cur_len = len_tab[cnt];
        nc_sel  = next_code[cur_len];
        // bl_count[0] is never incremented, so step b=1 adds zero.
        acc_nxt = (code_acc + CW'(bl_count[cnt])) << 1;
        oversub = (nc_sel >> cur_len) != '0;
    end

    // Main FSM plus table and shifter state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len_tab    <= '0;
            code_tab   <= '0;
            bl_count   <= '0;
            next_code  <= '0;
            code_acc   <= '0;
            shreg      <= '0;
            rem        <= '0;
            build_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            build_done <= 1'b0;
            case (state)
                S_IDLE, S_READY: begin
                    if (build) begin
                        if (len_we) len_tab[len_addr] <= len_data;
                        err      <= 1'b0;
                        bl_count <= '0;
                        code_acc <= '0;
                        cnt      <= '0;
                        state    <= S_COUNT;
                    end else if (state == S_READY && sym_valid) begin
                        // An accepted symbol is binding; a coincident length
                        // write is dropped rather than losing the symbol.
                        if (len_tab[sym] == 4'd0) begin
                            err <= 1'b1;
                        end else begin
                            shreg <= code_tab[sym];
                            rem   <= len_tab[sym];
                            state <= S_SHIFT;
                        end
                    end else if (len_we) begin
                        len_tab[len_addr] <= len_data;
                        state             <= S_IDLE;
                    end
                end
                S_COUNT: begin
                    if (cur_len != 4'd0) bl_count[cur_len] <= bl_count[cur_len] + 1'b1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(NSYM - 1)) begin
                        cnt   <= '0;
                        state <= S_NEXTC;
                    end
                end
                S_NEXTC: begin
                    // cnt = b-1 for bit length b
                    code_acc               <= acc_nxt;
                    next_code[cnt + 4'd1]  <= acc_nxt;
                    cnt                    <= cnt + 4'd1;
                    if (cnt == 4'(MAXLEN - 1)) begin
                        cnt   <= '0;
                        state <= S_ASSIGN;
                    end
                end
                S_ASSIGN: begin
                    if (cur_len != 4'd0) begin
                        code_tab[cnt]      <= nc_sel;
                        next_code[cur_len] <= nc_sel + 1'b1;
                        if (oversub) err <= 1'b1;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(NSYM - 1)) begin
                        cnt        <= '0;
                        build_done <= 1'b1;
                        state      <= S_READY;
                    end
                end
                S_SHIFT: begin
                    if (bit_ready) begin
                        if (rem == 4'd1) state <= S_READY;
                        else             rem   <= rem - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake and serial outputs decode straight from registered state.
    always_comb begin
        sym_ready = (state == S_READY) && !build;
        bit_valid = (state == S_SHIFT);
        bit_out   = bit_valid && shreg[rem - 4'd1];
        bit_last  = bit_valid && (rem == 4'd1);
        busy      = (state == S_COUNT) || (state == S_NEXTC) || (state == S_ASSIGN);
    end
endmodule

// File: tb/tb_huff_encode.sv
// Self-checking bench for huff_encode: table-driven symbol vectors with a
// bit scoreboard, plus hand sequences for stalls, resets and bad builds.
module tb_huff_encode;
    logic       clock = 1'b0, reset = 1'b1;
    logic       len_we = 1'b0, build = 1'b0, sym_valid = 1'b0, bit_ready = 1'b1;
    logic [3:0] len_addr = '0, len_data = '0, sym = '0;
    logic       build_done, sym_ready, bit_valid, bit_out, bit_last, busy, err;

    huff_encode #(.NSYM(16), .MAXLEN(15)) dut (
        .clock(clock), .reset(reset), .len_we(len_we), .len_addr(len_addr),
        .len_data(len_data), .build(build), .build_done(build_done),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
        .bit_valid(bit_valid), .bit_out(bit_out), .bit_last(bit_last),
        .bit_ready(bit_ready), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct { logic [3:0] s; logic [15:0] code; int len; } vec_t;
    typedef struct packed { logic b; logic last; } bit_t;

    int   tests = 0, fails = 0;
    bit_t exp_q[$];
    vec_t vecs[8];
    int   lens[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic write_len(input logic [3:0] a, input logic [3:0] d);
        len_we = 1'b1; len_addr = a; len_data = d;
        step();
        len_we = 1'b0;
    endtask

    task automatic do_build(input string nm, input logic exp_err);
        int n;
        build = 1'b1;
        step();
        build = 1'b0;
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_err_clr"}, err, 0);
        n = 0;
        while (!build_done && n < 100) begin step(); n++; end
        chk({nm, "_latency"}, n, 47);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_ready"}, sym_ready, 1);
    endtask

    task automatic send_sym(input logic [3:0] s, input logic [15:0] code, input int len);
        int n = 0;
        while (!sym_ready && n < 200) begin step(); n++; end
        chk("sym_ready_wait", n < 200, 1);
        sym_valid = 1'b1; sym = s;
        for (int i = len - 1; i >= 0; i--) exp_q.push_back(bit_t'{b: code[i], last: (i == 0)});
        step();
        sym_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || !sym_ready) && n < 200) begin step(); n++; end
        chk({nm, "_drain"}, n < 200, 1);
    endtask

    // Scoreboard: every accepted bit is compared against the queued expectation.
    always @(negedge clock) begin
        bit_t e;
        if (bit_valid && bit_ready) begin
            if (exp_q.size() == 0) chk("unexpected_bit", bit_valid, 0);
            else begin
                e = exp_q.pop_front();
                chk("bit_out", bit_out, e.b);
                chk("bit_last", bit_last, e.last);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lens = '{3, 3, 3, 3, 3, 2, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[0] = '{4'd5, 16'b00,   2};
        vecs[1] = '{4'd0, 16'b010,  3};
        vecs[2] = '{4'd1, 16'b011,  3};
        vecs[3] = '{4'd2, 16'b100,  3};
        vecs[4] = '{4'd3, 16'b101,  3};
        vecs[5] = '{4'd4, 16'b110,  3};
        vecs[6] = '{4'd6, 16'b1110, 4};
        vecs[7] = '{4'd7, 16'b1111, 4};

        repeat (3) step();
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_build_done", build_done, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 16; i++) write_len(4'(i), 4'(lens[i]));
        do_build("build1", 1'b0);

        for (int i = 0; i < 8; i++) begin
            send_sym(vecs[i].s, vecs[i].code, vecs[i].len);
            wait_drain($sformatf("vec%0d", i));
        end

        // Back-to-back timing for sym 6
        send_sym(4'd6, 16'b1110, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s6_valid%0d", i), bit_valid, 1);
            step();
        end
        chk("s6_ready_after", sym_ready, 1);
        chk("s6_valid_after", bit_valid, 0);

        // Stall on the first bit of sym 0
        bit_ready = 1'b0;
        send_sym(4'd0, 16'b010, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_valid%0d", i), bit_valid, 1);
            chk($sformatf("stall_out%0d", i), bit_out, 0);
            chk($sformatf("stall_last%0d", i), bit_last, 0);
            step();
        end
        bit_ready = 1'b1;
        wait_drain("stall");

        // Zero-length symbol is dropped with err
        send_sym(4'd9, 16'b0, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s9_novalid%0d", i), bit_valid, 0);
            step();
        end
        chk("s9_err", err, 1);
        chk("s9_ready", sym_ready, 1);

        // Oversubscribed table
        for (int i = 0; i < 16; i++) write_len(4'(i), 4'd1);
        do_build("build_all1", 1'b1);

        // Reload, then reset on the 2nd bit of sym 7
        for (int i = 0; i < 16; i++) write_len(4'(i), 4'(lens[i]));
        do_build("build2", 1'b0);
        send_sym(4'd7, 16'b1111, 4);
        step();
        reset = 1'b1;
        step();
        chk("rst7_bit_valid", bit_valid, 0);
        chk("rst7_sym_ready", sym_ready, 0);
        chk("rst7_busy", busy, 0);
        chk("rst7_err", err, 0);
        reset = 1'b0;
        exp_q.delete();
        step();

        // Tables were cleared: a build with no load leaves every symbol unused
        do_build("build_empty", 1'b0);
        send_sym(4'd7, 16'b0, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("empty_novalid%0d", i), bit_valid, 0);
            step();
        end
        chk("empty_err", err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/huff_encode.md
HUFF_ENCODE -- requirements
Module: huff_encode

Interface
REQ-001 Parameter NSYM, 16, number of symbols in the alphabet.
REQ-002 Parameter MAXLEN, 15, maximum code length in bits.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 len_we  in  1  code-length table write strobe.
REQ-006 len_addr  in  4  symbol index for the length write.
REQ-007 len_data  in  4  code length for the symbol; 0 means unused.
REQ-008 build  in  1  starts the canonical code table build.
REQ-009 build_done  out  1  one-cycle pulse when the table is ready.
REQ-010 sym_valid  in  1  symbol offered.
REQ-011 sym  in  4  symbol index.
REQ-012 sym_ready  out  1  symbol accepted when sym_valid and sym_ready are high together.
REQ-013 bit_valid  out  1  serial code bit valid.
REQ-014 bit_out  out  1  serial code bit, MSB of the code first.
REQ-015 bit_last  out  1  marks the final bit of the current code.
REQ-016 bit_ready  in  1  downstream accepts the bit.
REQ-017 busy  out  1  high in the COUNT, NEXTC and ASSIGN states.
REQ-018 err  out  1  sticky error flag.

Function
REQ-019 The block SHALL implement the states IDLE, COUNT, NEXTC, ASSIGN, READY and SHIFT.
REQ-020 A length write SHALL occur only in IDLE or READY; a write in READY SHALL return the FSM to IDLE; len_we SHALL be ignored in all other states.
REQ-021 build sampled high in IDLE or READY SHALL clear err and the bl_count table, then enter COUNT.
REQ-022 COUNT SHALL take 16 cycles, one symbol per cycle, incrementing bl_count[len] for each nonzero length.
REQ-023 NEXTC SHALL take 15 cycles, one per bit length b = 1..15: code = (code + bl_count[b-1]) << 1, with bl_count[0] = 0 and code starting at 0; next_code[b] = code.
  - Arithmetic SHALL be 16 bits wide with no truncation.
REQ-024 ASSIGN SHALL take 16 cycles, symbols in ascending order; for a nonzero length L: code[n] = next_code[L], then next_code[L] is incremented.
REQ-025 In ASSIGN, an assigned code >= 2^L (oversubscribed) SHALL set err; the build SHALL still complete.
REQ-026 build_done SHALL pulse on the first READY cycle, 47 clocks after the build-sampling edge.
REQ-027 sym_ready SHALL equal (state == READY) and not build.
  - When build and sym_valid arrive together, build wins.
REQ-028 An accepted symbol with length 0 SHALL set err, be dropped, and leave the FSM in READY.
REQ-029 An accepted symbol with length L > 0 SHALL load code[n] and L, then enter SHIFT on the next cycle.
REQ-030 In SHIFT:
  - bit_valid = 1 and bit_out = code bit (remaining - 1).
  - The bit SHALL advance only on bit_valid and bit_ready.
  - bit_last = 1 when remaining == 1.
REQ-031 After the last bit is accepted, the FSM SHALL return to READY; peak throughput is one symbol per L+1 cycles.
REQ-032 While bit_ready is low, bit_out and bit_last SHALL hold stable.
REQ-033 A build or length write SHALL NOT be accepted in SHIFT; the block finishes the current code first.

Reset
REQ-034 Reset SHALL force:
  - state to IDLE;
  - the length, code, bl_count and next_code tables to 0;
  - build_done, sym_ready, bit_valid, bit_out, bit_last, busy and err to 0.
REQ-035 Reset asserted mid-build or mid-SHIFT SHALL abort immediately with no further bit_valid; the table SHALL need a fresh load and build.

Verification
REQ-036 Load lengths 3,3,3,3,3,2,4,4 for symbols 0-7 (others 0), then build:
  - build_done 47 cycles later, err = 0;
  - codes sym5 = 00, sym0 = 010, sym1 = 011, sym2 = 100, sym3 = 101, sym4 = 110, sym6 = 1110, sym7 = 1111.
REQ-037 With that table and bit_ready held 1, send sym 6 -> bits 1,1,1,0 on consecutive cycles, bit_last on the 4th, sym_ready again 1 cycle later.
REQ-038 Send sym 0 with bit_ready low for 3 cycles after the first bit -> bit_out holds 0 and bit_valid holds 1; sequence 0,1,0 resumes intact.
REQ-039 Send sym 9 (length 0) -> err = 1, no bit_valid, sym_ready stays 1.
REQ-040 Set all 16 lengths to 1 and build -> err = 1, build_done still pulses.
REQ-041 Assert reset on the 2nd bit of sym 7 -> bit_valid = 0 next cycle, state IDLE, all tables 0.
